restoring_unsigned_divider: RTL
===============================

# restoring_unsigned_divider

Iterative unsigned integer divider, the inverse of the unsigned multipliers: it computes quotient = A / B and remainder = A % B for N-bit operands. It uses a start/done handshake and takes one quotient bit per clock (restoring algorithm). It is the division reference datapath for the multiplier suite: product/divider round-trip benches feed a multiplier's product and one operand back through this block.

## Interface
Parameters:
- N, 4, operand width in bits. Legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division. Sampled only in IDLE.
- A  input  N  dividend. Sampled with start.
- B  input  N  divisor. Sampled with start.
- quotient  output  N  registered result, valid from done until the next accepted start.
- remainder  output  N  registered result, same validity as quotient.
- busy  output  1  high from the cycle after start is accepted through the done cycle.
- done  output  1  one-cycle pulse when the results become valid.
- div_by_zero  output  1  registered flag, qualifies quotient/remainder. Same validity window.

## Operation
- States are IDLE, CALC and DONE.
- IDLE:
  - start=1 latches A into the dividend shift register and B into the divisor register.
  - It clears the partial remainder (N+1 bits), sets the step counter to N-1 and enters CALC.
  - start=0 keeps the block in IDLE.
- CALC, one step per cycle:
  - t = {rem[N-1:0], dividend MSB} - {1'b0, divisor}, computed at N+1 bits.
  - If t is non-negative (borrow clear): rem <= t and quotient bit = 1.
  - Otherwise: rem <= the shifted value and quotient bit = 0.
  - The dividend shifts left, and the quotient bit enters the vacated LSB, so the same register ends as the quotient.
  - When the counter reaches 0, the next state is DONE. Otherwise the counter decrements.
- DONE:
  - quotient, remainder and div_by_zero are loaded. done=1 for exactly this cycle.
  - The next state is IDLE unconditionally.
- B=0 runs the same N steps without special-casing. The result is quotient = all ones (2^N-1), remainder = A, div_by_zero=1.
- start asserted in CALC or DONE is ignored, with no queuing. The caller must re-assert start in IDLE.
- Outputs hold their last values in IDLE and CALC. They change only in DONE and on reset.

## Timing
- Reset values: quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, state=IDLE, all internal registers 0.
- Reset applied mid-operation aborts the division at the next edge. No done is produced for the aborted operation.
- Latency is fixed and independent of operand values, including B=0:
  - start sampled at edge 0.
  - CALC occupies cycles 1..N.
  - done=1 in cycle N+1.
  - Back in IDLE at cycle N+2.
- Maximum throughput is one division per N+2 cycles. start may be held high continuously, which gives exactly that rate.
- busy=1 in cycles 1..N+1 and 0 in IDLE. done and busy are both registered, with no combinational path from start.
- Width rules:
  - The partial remainder is N+1 bits, so the subtract borrow is its MSB.
  - The final remainder is the low N bits and is always < B when B≠0.

## Structure
- Shared package div_pkg:
  - State encoding localparams: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - Counter width function clog2(N).
- One combinational sub-module, restoring_div_step (width N+1). It takes the shifted remainder and the divisor, and returns the new remainder and the quotient bit.
  - It isolates the subtractor so a Kogge-Stone or ripple variant can be swapped in, matching the suite's adder variants.

## Test plan (N=4)
- A=13, B=3, start for 1 cycle -> done exactly 5 cycles after the start edge; quotient=4, remainder=1, div_by_zero=0, busy high for 5 cycles.
- A=2, B=7 -> quotient=0, remainder=2. Then A=15, B=1 -> quotient=15, remainder=0.
- A=9, B=0 -> quotient=15, remainder=9, div_by_zero=1, same 5-cycle latency.
- start held high, with A=6, B=3 then A=10, B=3 presented -> results 2/0 then 3/1. Consecutive done pulses are 6 cycles apart. A start pulse during CALC is ignored and the outputs are unchanged.
- A=13, B=3, with rst asserted in cycle 2 -> no done; all outputs 0 the cycle after reset; the next start with A=12, B=4 gives quotient=3, remainder=0.
- Exhaustive sweep of all 256 A/B pairs against the behavioural / and %. The B=0 convention is checked separately.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and
// a counter-width helper.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bits needed to hold values 0..value-1, never less than one bit.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) begin
         w = w + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/restoring_unsigned_divider_if.sv
// Start/done handshake and operand/result bundle for the restoring divider.
interface restoring_unsigned_divider_if #(parameter int N = 4);

   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;

   modport master (
      output start, A, B,
      input  quotient, remainder, busy, done, div_by_zero
   );

   modport slave (
      input  start, A, B,
      output quotient, remainder, busy, done, div_by_zero
   );

endinterface

// File: rtl/restoring_div_step.sv
// One restoring-division step: trial subtract at full width, keep the
// difference when it does not borrow, otherwise restore the shifted value.
module restoring_div_step #(
   parameter int W = 5
) (
   input  logic [W-1:0] shifted_rem,
   input  logic [W-1:0] divisor,
   output logic [W-2:0] new_rem,
   output logic         q_bit
);

   logic [W-1:0] diff;

   // The MSB of the W-bit difference is the borrow. Either surviving value
   // is below 2^(W-1), so the top bit of the new remainder is always zero
   // and is not returned.
   always_comb begin
      diff    = shifted_rem - divisor;
      q_bit   = ~diff[W-1];
      new_rem = q_bit ? diff[W-2:0] : shifted_rem[W-2:0];
   end

endmodule

// File: rtl/restoring_unsigned_divider.sv
// Iterative N-bit unsigned divider, one quotient bit per clock.
// Fixed latency of N+1 cycles from the accepted start to the done pulse.
module restoring_unsigned_divider
   import div_pkg::*;
#(
   parameter int N = 4
) (
   input logic clk,
   input logic rst,
   restoring_unsigned_divider_if.slave bus
);

   localparam int CW = clog2(N);

   state_t        state;
   state_t        state_next;
   logic [N-1:0]  dividend;
   logic [N-1:0]  divisor;
   logic [N-1:0]  rem;
   logic [CW-1:0] count;
   logic [N-1:0]  quotient_r;
   logic [N-1:0]  remainder_r;
   logic          busy_r;
   logic          done_r;
   logic          dbz_r;

   logic [N:0]    shifted;
   logic [N-1:0]  step_rem;
   logic          q_bit;

   assign shifted = {rem, dividend[N-1]};

   restoring_div_step #(.W(N + 1)) u_step (
      .shifted_rem (shifted),
      .divisor     ({1'b0, divisor}),
      .new_rem     (step_rem),
      .q_bit       (q_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (bus.start) state_next = CALC;
         CALC:    if (count == '0) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The dividend register doubles as the quotient: each step shifts the
   // next dividend bit out of the top and the new quotient bit in at the
   // bottom. Results are captured on the final step so they are already
   // valid while done is high.
   always_ff @(posedge clk) begin
      if (rst) begin
         dividend    <= '0;
         divisor     <= '0;
         rem         <= '0;
         count       <= '0;
         quotient_r  <= '0;
         remainder_r <= '0;
         dbz_r       <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         busy_r <= (state_next != IDLE);
         done_r <= (state_next == DONE);
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  dividend <= bus.A;
                  divisor  <= bus.B;
                  rem      <= '0;
                  count    <= CW'(N - 1);
               end
            end
            CALC: begin
               rem      <= step_rem;
               dividend <= {dividend[N-2:0], q_bit};
               if (count != '0) begin
                  count <= count - CW'(1);
               end else begin
                  quotient_r  <= {dividend[N-2:0], q_bit};
                  remainder_r <= step_rem;
                  dbz_r       <= (divisor == '0);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.quotient    = quotient_r;
   assign bus.remainder   = remainder_r;
   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.div_by_zero = dbz_r;

endmodule
